led_blink_driver: RTL and testbench
===================================

Name: led_blink_driver

Overview:
- Output-side counterpart to the board's switch-edge input logic.
- Turns a single accepted request into a visible sequence of N LED blinks, each with a fixed on-time and off-time.
- Sits between control logic, such as a debounced switch event or a status FSM, and a physical LED pin.
- Signals completion with a one-cycle done pulse.

Parameters:
- CLKS_PER_ON, 2500000, cycles the LED is held high per blink (≥1); 100 ms at 25 MHz.
- CLKS_PER_OFF, 2500000, cycles the LED is held low after each blink (≥1).
- COUNT_W, 4, width of the blink-count field.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  reset, synchronous, active-low
- i_Req_Valid  in  1  request strobe/level
- i_Blink_Count  in  COUNT_W  number of blinks for this request; sampled on accept
- o_Req_Ready  out  1  block can accept a request this cycle
- o_LED  out  1  LED drive, active-high
- o_Busy  out  1  a sequence is in progress
- o_Done  out  1  one-cycle pulse when a sequence finishes

Behaviour:
- Interface: one clock, i_Clk; reset i_Rst_L is synchronous and active-low. All outputs are registered.
- Reset (i_Rst_L=0 at a posedge), including mid-sequence:
  - state=IDLE; o_LED=0, o_Busy=0, o_Done=0, o_Req_Ready=1.
  - Timer and remaining-count registers are cleared.
  - Any in-flight sequence is discarded; no done pulse.
- Accept: happens when i_Req_Valid && o_Req_Ready at a posedge. i_Blink_Count is latched into rem.
- FSM states:
  - IDLE: o_Req_Ready=1. On accept with count>0, go to ON and set o_LED=1 on the next cycle (latency 1). On accept with count=0, stay in IDLE and pulse o_Done on the next cycle, with no LED activity.
  - ON: o_LED=1 for exactly CLKS_PER_ON cycles, then go to OFF and decrement rem.
  - OFF: o_LED=0 for exactly CLKS_PER_OFF cycles. At expiry: if rem≠0, go to ON; if rem=0, go to IDLE with o_Done=1 for one cycle.
- o_Busy=1 in ON and OFF. o_Req_Ready=0 in ON and OFF (base build).
- Timer is a down-counter of width $clog2(max(CLKS_PER_ON, CLKS_PER_OFF)+1). It is reloaded on every state entry.
- Total sequence length for count N: N*(CLKS_PER_ON+CLKS_PER_OFF) cycles from the first LED-high cycle to the o_Done cycle (inclusive of OFF).
- Requests presented while busy are ignored, not queued (base build).
- Maximum count is 2^COUNT_W−1; counts do not wrap.

Optional Feature:
- Macro: LED_BLINK_QUEUE_EN.
- Defined:
  - Adds a one-deep pending slot (pend_valid, pend_count).
  - While busy, o_Req_Ready = ~pend_valid; an accept stores into the slot.
  - At the final OFF expiry with pend_valid=1: o_Done still pulses, the FSM goes directly to ON with rem=pend_count (no IDLE cycle), and the slot is cleared.
  - If pend_count=0, o_Done pulses twice, on consecutive cycles, and the FSM goes to IDLE.
  - Reset clears the slot.
- Undefined: behaviour is exactly as specified in Behaviour.

Decomposition:
- Package led_blink_pkg holds:
  - State encoding: IDLE=2'd0, ON=2'd1, OFF=2'd2.
  - A timer-width helper function.
- One sub-module, blink_timer:
  - Parameterised down-counter with load and value inputs and an expire output.
  - Instantiated once and shared by ON and OFF.

Test Plan:
- Params ON=4, OFF=3. Reset, then valid with count=2 → LED high on cycles 1–4, low 5–7, high 8–11, low 12–14; o_Done at cycle 14; ready low throughout.
- count=0 accept → o_Done pulses on the next cycle; o_LED stays 0; o_Busy stays 0.
- Valid held during a count=3 sequence (base build) → no extra accepts; exactly 3 blinks and 1 done.
- i_Rst_L low for 1 cycle during the 2nd ON phase → next cycle o_LED=0, o_Busy=0, ready=1; no o_Done.
- Count=15 (max) → 15 blinks, 105 cycles total, single done.
- LED_BLINK_QUEUE_EN: accept 1, then accept 2 while busy → ready drops after the 2nd accept; 3 blinks back-to-back; o_Done at end of the 1st and 2nd sequences.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink driver.
// State encoding is fixed so that external debug taps can decode it.
package led_blink_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    // Phase timer width: enough bits to hold the longer of the two phase lengths.
    function automatic int unsigned timer_width(input int unsigned on_clks,
                                                input int unsigned off_clks);
        int unsigned longest;
        longest = (on_clks > off_clks) ? on_clks : off_clks;
        return (longest < 2) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/led_blink_driver_blink_timer.sv
// blink_timer: loadable down-counter shared by the ON and OFF phases.
// expire_o flags the last cycle of a phase (count is zero); expire_next_o is
// the same flag for the value the counter will hold after the coming edge,
// which lets the parent register outputs one cycle ahead.
module blink_timer #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             expire_o,
    output logic             expire_next_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load on phase entry, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o      = (cnt_q == '0);
    assign expire_next_o = (cnt_d == '0);

endmodule

// File: rtl/led_blink_driver.sv
// led_blink_driver: turns one accepted request into N LED blinks of fixed
// on/off length and pulses o_Done for one cycle when the sequence ends.
// All outputs are registered; o_Done coincides with the final OFF cycle.
// Optional build macro LED_BLINK_QUEUE_EN adds a one-deep pending request
// slot so a new sequence can be queued while one is running.
module led_blink_driver
    import led_blink_pkg::*;
#(
    parameter int unsigned CLKS_PER_ON  = 2500000,
    parameter int unsigned CLKS_PER_OFF = 2500000,
    parameter int unsigned COUNT_W      = 4
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Req_Valid,
    input  logic [COUNT_W-1:0] i_Blink_Count,
    output logic               o_Req_Ready,
    output logic               o_LED,
    output logic               o_Busy,
    output logic               o_Done
);

    localparam int unsigned TimerW = timer_width(CLKS_PER_ON, CLKS_PER_OFF);
    // Timer counts down to zero inclusive, so a phase of N cycles loads N-1.
    localparam logic [TimerW-1:0] OnLoad  = TimerW'(CLKS_PER_ON - 1);
    localparam logic [TimerW-1:0] OffLoad = TimerW'(CLKS_PER_OFF - 1);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic               accept;
    logic               start_en;
    logic [COUNT_W-1:0] start_count;
    logic               done_now;

    logic               tmr_load;
    logic [TimerW-1:0]  tmr_value;
    logic               tmr_expire;
    logic               tmr_expire_next;

`ifdef LED_BLINK_QUEUE_EN
    logic               pend_valid_q, pend_valid_d;
    logic [COUNT_W-1:0] pend_count_q, pend_count_d;
`endif

    assign accept = i_Req_Valid && ready_q;

    blink_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i         (i_Clk),
        .rst_ni        (i_Rst_L),
        .load_i        (tmr_load),
        .value_i       (tmr_value),
        .expire_o      (tmr_expire),
        .expire_next_o (tmr_expire_next)
    );

    // Next-state, remaining-count and timer control.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        start_en    = 1'b0;
        start_count = '0;
        done_now    = 1'b0;
`ifdef LED_BLINK_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_count_d = pend_count_q;
        // While busy, ready implies an empty slot, so any accept lands here
        // unless the final-expiry branch below consumes it directly.
        if (accept && (state_q != StIdle)) begin
            pend_valid_d = 1'b1;
            pend_count_d = i_Blink_Count;
        end
`endif

        case (state_q)
            StIdle: begin
                if (accept) begin
                    start_en    = 1'b1;
                    start_count = i_Blink_Count;
                end
            end
            StOn: begin
                if (tmr_expire) begin
                    state_d   = StOff;
                    rem_d     = rem_q - COUNT_W'(1);
                    tmr_load  = 1'b1;
                    tmr_value = OffLoad;
                end
            end
            StOff: begin
                if (tmr_expire) begin
                    if (rem_q != '0) begin
                        state_d   = StOn;
                        tmr_load  = 1'b1;
                        tmr_value = OnLoad;
                    end else begin
                        state_d = StIdle;
`ifdef LED_BLINK_QUEUE_EN
                        // Chain straight into the queued request, or into one
                        // arriving on this very edge, without an idle cycle.
                        if (pend_valid_q) begin
                            start_en     = 1'b1;
                            start_count  = pend_count_q;
                            pend_valid_d = 1'b0;
                        end else if (accept) begin
                            start_en     = 1'b1;
                            start_count  = i_Blink_Count;
                            pend_valid_d = 1'b0;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A zero-count request finishes immediately with only a done pulse.
        if (start_en) begin
            if (start_count != '0) begin
                state_d   = StOn;
                rem_d     = start_count;
                tmr_load  = 1'b1;
                tmr_value = OnLoad;
            end else begin
                state_d  = StIdle;
                done_now = 1'b1;
            end
        end
    end

    // Registered output values derived from the upcoming state.
    always_comb begin
        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
        // Done rides on the last OFF cycle of a sequence whose count is spent.
        done_d = done_now ||
                 ((state_d == StOff) && tmr_expire_next && (rem_d == '0));
`ifdef LED_BLINK_QUEUE_EN
        ready_d = (state_d == StIdle) || !pend_valid_d;
`else
        ready_d = (state_d == StIdle);
`endif
    end

    // State and output registers; reset drops any in-flight sequence silently.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q <= StIdle;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef LED_BLINK_QUEUE_EN
    // Pending request slot.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            pend_valid_q <= 1'b0;
            pend_count_q <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_count_q <= pend_count_d;
        end
    end
`endif

    assign o_Req_Ready = ready_q;
    assign o_LED       = led_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Self-checking bench for led_blink_driver with ON=4, OFF=3, COUNT_W=4.
module tb_led_blink_driver;

    localparam int unsigned ON  = 4;
    localparam int unsigned OFF = 3;
    localparam int unsigned CW  = 4;
    localparam int PER = ON + OFF;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          valid;
    logic [CW-1:0] cnt;
    logic          ready, led, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_blink_driver #(
        .CLKS_PER_ON  (ON),
        .CLKS_PER_OFF (OFF),
        .COUNT_W      (CW)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_l),
        .i_Req_Valid   (valid),
        .i_Blink_Count (cnt),
        .o_Req_Ready   (ready),
        .o_LED         (led),
        .o_Busy        (busy),
        .o_Done        (done)
    );

    typedef struct {
        logic          rst_l;
        logic          valid;
        logic [CW-1:0] cnt;
        logic          led;
        logic          busy;
        logic          ready;
        logic          done;
    } vec_t;

    vec_t vecs[18];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        valid = 1'b0;
        cnt   = '0;
        tick();
        rst_l = 1'b1;
    endtask

    // Behavioural model state: active window [ws, we] and zero-count done cycle.
    int cyc, ws, we, zd;

    function automatic bit in_win(input int c);
        return (we >= 0) && (c >= ws) && (c <= we);
    endfunction

    initial begin
        int rises, dones, done_at;
        logic prev_led;
        rst_l = 1'b0;
        valid = 1'b0;
        cnt   = '0;

        // ---- table: reset, count=2 trace, count=0 accept ----
        vecs[0] = '{rst_l: 1'b0, valid: 1'b0, cnt: 4'd0, led: 1'b0, busy: 1'b0,
                    ready: 1'b1, done: 1'b0};
        for (int c = 1; c <= 15; c++) begin
            vecs[c].rst_l = 1'b1;
            vecs[c].valid = (c == 1);
            vecs[c].cnt   = (c == 1) ? 4'd2 : 4'd0;
            vecs[c].led   = ((c >= 1) && (c <= 4)) || ((c >= 8) && (c <= 11));
            vecs[c].busy  = (c <= 14);
            vecs[c].ready = (c == 15);
            vecs[c].done  = (c == 14);
        end
        vecs[16] = '{rst_l: 1'b1, valid: 1'b1, cnt: 4'd0, led: 1'b0, busy: 1'b0,
                     ready: 1'b1, done: 1'b1};
        vecs[17] = '{rst_l: 1'b1, valid: 1'b0, cnt: 4'd0, led: 1'b0, busy: 1'b0,
                     ready: 1'b1, done: 1'b0};

        for (int i = 0; i < 18; i++) begin
            rst_l = vecs[i].rst_l;
            valid = vecs[i].valid;
            cnt   = vecs[i].cnt;
            tick();
            check_bit($sformatf("vec%0d_led", i), led, vecs[i].led);
            check_bit($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check_bit($sformatf("vec%0d_ready", i), ready, vecs[i].ready);
            check_bit($sformatf("vec%0d_done", i), done, vecs[i].done);
        end

`ifndef LED_BLINK_QUEUE_EN
        // ---- valid held during a count=3 sequence ----
        do_reset();
        valid = 1'b1;
        cnt   = 4'd3;
        rises = 0;
        dones = 0;
        prev_led = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (led && !prev_led) rises++;
            prev_led = led;
            if (done) dones++;
            if (c == 21) begin
                check_bit("hold_done_at_21", done, 1'b1);
                check_bit("hold_ready_at_21", ready, 1'b0);
                valid = 1'b0;
            end
        end
        check_int("hold_blinks", rises, 3);
        check_int("hold_dones", dones, 1);
`endif

        // ---- reset during 2nd ON phase ----
        do_reset();
        valid = 1'b1;
        cnt   = 4'd2;
        tick();
        valid = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        check_bit("pre_rst_led", led, 1'b1);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        check_bit("rst_led", led, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_ready", ready, 1'b1);
        check_bit("rst_done", done, 1'b0);
        dones = 0;
        rises = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) dones++;
            if (led) rises++;
        end
        check_int("post_rst_dones", dones, 0);
        check_int("post_rst_led_cycles", rises, 0);

        // ---- maximum count ----
        do_reset();
        valid = 1'b1;
        cnt   = 4'd15;
        tick();
        valid = 1'b0;
        rises = 1;
        dones = 0;
        done_at = -1;
        prev_led = led;
        for (int c = 2; c <= 106; c++) begin
            tick();
            if (led && !prev_led) rises++;
            prev_led = led;
            if (done) begin
                dones++;
                done_at = c;
            end
            if (c == 106) check_bit("max_ready_after", ready, 1'b1);
        end
        check_int("max_blinks", rises, 15);
        check_int("max_dones", dones, 1);
        check_int("max_done_cycle", done_at, 15 * PER);

`ifdef LED_BLINK_QUEUE_EN
        // ---- queued request chains back-to-back ----
        do_reset();
        valid = 1'b1;
        cnt   = 4'd1;
        tick();
        check_bit("q_ready_busy_empty", ready, 1'b1);
        valid = 1'b0;
        tick();
        valid = 1'b1;
        cnt   = 4'd2;
        tick();
        valid = 1'b0;
        check_bit("q_ready_after_2nd", ready, 1'b0);
        rises = 1;
        dones = 0;
        prev_led = led;
        for (int c = 4; c <= 30; c++) begin
            tick();
            if (led && !prev_led) rises++;
            prev_led = led;
            if (done) dones++;
            if (c == 7) check_bit("q_done_first", done, 1'b1);
            if (c == 8) check_bit("q_led_chain", led, 1'b1);
            if (c == 21) check_bit("q_done_second", done, 1'b1);
        end
        check_int("q_blinks", rises, 3);
        check_int("q_dones", dones, 2);
`else
        // ---- randomized run against the behavioural model ----
        cyc = 0;
        we  = -1;
        ws  = 0;
        zd  = -1;
        for (int i = 0; i < 3000; i++) begin
            bit prev_ready;
            bit exp_led, exp_busy, exp_ready, exp_done;
            rst_l = (i == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
            valid = ($urandom_range(0, 3) == 0);
            cnt   = CW'($urandom_range(0, 4));
            prev_ready = !in_win(cyc);
            tick();
            cyc++;
            if (!rst_l) begin
                we = -1;
                zd = -1;
            end else if (valid && prev_ready) begin
                if (cnt != 0) begin
                    ws = cyc;
                    we = cyc + int'(cnt) * PER - 1;
                end else begin
                    zd = cyc;
                end
            end
            exp_busy  = in_win(cyc);
            exp_ready = !exp_busy;
            exp_led   = exp_busy && (((cyc - ws) % PER) < ON);
            exp_done  = (exp_busy && (cyc == we)) || (zd == cyc);
            check_bit("rand_led", led, exp_led);
            check_bit("rand_busy", busy, exp_busy);
            check_bit("rand_ready", ready, exp_ready);
            check_bit("rand_done", done, exp_done);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
